// File: rtl/chan_mux_pkg.sv
// Shared constants for the N-channel valid/ready mux with round-robin arbitration.
package chan_mux_pkg;
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;
   localparam int   NCH_DEF    = 4;
   localparam int   W_DEF      = 8;
endpackage

// File: rtl/chan_mux_rr_arbiter.sv
// Combinational round-robin search: first requester after ptr, wrapping modulo NCH.
module rr_arbiter #(
   parameter int NCH   = 4,
   parameter int SEL_W = $clog2(NCH)
) (
   input  logic [NCH-1:0]   req,
   input  logic [SEL_W-1:0] ptr,
   output logic [NCH-1:0]   gnt,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             any
);
   // Walk the search order backwards so the closest requester to ptr+1 wins last.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int k = NCH; k >= 1; k--) begin
         int idx;
         idx = (int'(ptr) + k) % NCH;
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            gnt_idx  = SEL_W'(idx);
            any      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/chan_mux_rr.sv
// N-channel valid/ready mux, fixed-select or round-robin, one-entry registered output.
// Optional CHMUX_PARITY_EN adds a registered even-parity bit out_par.
module chan_mux_rr
   import chan_mux_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int W     = W_DEF,
   parameter int SEL_W = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH*W-1:0] in_data,
   input  logic [NCH-1:0]   in_valid,
   output logic [NCH-1:0]   in_ready,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel,
   output logic [W-1:0]     out_data,
   output logic [SEL_W-1:0] out_chan,
   output logic             out_valid,
   input  logic             out_ready
`ifdef CHMUX_PARITY_EN
   ,
   output logic             out_par
`endif
);
   logic [NCH-1:0]   gnt_rr, gnt_fix, gnt;
   logic [SEL_W-1:0] rr_idx, gnt_idx;
   logic             rr_any, any_gnt, load, xfer;
   logic [W-1:0]     win_data;

   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_data_q, out_data_d;
   logic [SEL_W-1:0] out_chan_q, out_chan_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             par_q, par_d;

   rr_arbiter #(.NCH(NCH), .SEL_W(SEL_W)) u_arb (
      .req    (in_valid),
      .ptr    (rr_ptr_q),
      .gnt    (gnt_rr),
      .gnt_idx(rr_idx),
      .any    (rr_any)
   );

   // Out-of-range select simply grants nothing.
   always_comb begin
      gnt_fix = '0;
      if (int'(sel) < NCH) gnt_fix[sel] = in_valid[sel];
   end

   assign load     = ~out_valid_q | out_ready;
   assign gnt      = (mode == MODE_RR) ? gnt_rr : gnt_fix;
   assign gnt_idx  = (mode == MODE_RR) ? rr_idx : sel;
   assign any_gnt  = (mode == MODE_RR) ? rr_any : |gnt_fix;
   assign xfer     = load & any_gnt;
   assign in_ready = {NCH{load}} & gnt;

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NCH; i++)
         if (gnt[i]) win_data = in_data[i*W +: W];
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      rr_ptr_d    = rr_ptr_q;
      par_d       = par_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = win_data;
         out_chan_d  = gnt_idx;
         par_d       = ^win_data;
         if (mode == MODE_RR) rr_ptr_d = gnt_idx;
      end else if (out_ready & out_valid_q) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         rr_ptr_q    <= SEL_W'(NCH - 1);
         par_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         rr_ptr_q    <= rr_ptr_d;
         par_q       <= par_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
`ifdef CHMUX_PARITY_EN
   assign out_par   = par_q;
`else
   logic unused_par;
   assign unused_par = par_q;
`endif
endmodule

// File: tb/tb_chan_mux_rr.sv
// Randomized + directed bench for chan_mux_rr against a behavioural transfer model.
module tb_chan_mux_rr;
   localparam int NCH = 4;
   localparam int W   = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [NCH*W-1:0] in_data;
   logic [NCH-1:0]   in_valid, in_ready;
   logic             mode;
   logic [1:0]       sel;
   logic [W-1:0]     out_data;
   logic [1:0]       out_chan;
   logic             out_valid, out_ready;
`ifdef CHMUX_PARITY_EN
   logic             out_par;
`endif

   int total = 0;
   int bad   = 0;

   // reference state: what the consumer sees, plus last round-robin winner
   int         m_ptr;
   logic       m_vld;
   logic [7:0] m_data;
   int         m_chan;

   chan_mux_rr #(.NCH(NCH), .W(W)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
`ifdef CHMUX_PARITY_EN
      , .out_par(out_par)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = NCH - 1; m_vld = 1'b0; m_data = 8'h00; m_chan = 0;
   endtask

   // One cycle: drive, check ready combinationally, clock, check registered outputs.
   task automatic step(input logic m, input int s, input logic [3:0] v,
                       input logic [31:0] d, input logic r);
      int g;
      logic [3:0] exp_rdy;
      mode = m; sel = 2'(s); in_valid = v; in_data = d; out_ready = r;
      #2;
      g = -1;
      if (m == 1'b0) begin
         if (s < NCH && v[s]) g = s;
      end else begin
         for (int k = 1; k <= NCH && g < 0; k++)
            if (v[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
      end
      exp_rdy = ((!m_vld || r) && g >= 0) ? 4'(1 << g) : 4'b0000;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      if (exp_rdy != 4'b0000) begin
         m_vld = 1'b1; m_data = d[g*8 +: 8]; m_chan = g;
         if (m) m_ptr = g;
      end else if (r && m_vld) begin
         m_vld = 1'b0;
      end
      chk("out_valid", 32'(out_valid), 32'(m_vld));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_chan", 32'(out_chan), 32'(m_chan));
`ifdef CHMUX_PARITY_EN
      chk("out_par", 32'(out_par), 32'(^m_data));
`endif
   endtask

   initial begin
      logic [7:0] hold_d;
      logic [1:0] hold_c;
      rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = '0; in_data = '0; out_ready = 1'b0;
      model_reset();
      #3;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_chan", 32'(out_chan), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // fixed select
      step(1'b0, 2, 4'b1111, 32'h44A5_2211, 1'b1);
      chk("fix_data", 32'(out_data), 32'hA5);
      chk("fix_chan", 32'(out_chan), 32'd2);

      // round-robin fairness from reset pointer
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 0, 4'b1111, $urandom, 1'b1);
         chk("rr_seq", 32'(out_chan), 32'(i % NCH));
         chk("rr_nobubble", 32'(out_valid), 32'd1);
      end

      // back-pressure then drain
      hold_d = out_data; hold_c = out_chan;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 0, 4'b1111, $urandom, 1'b0);
         chk("bp_data", 32'(out_data), 32'(hold_d));
         chk("bp_chan", 32'(out_chan), 32'(hold_c));
      end
      step(1'b1, 0, 4'b1111, 32'hDDCC_BBAA, 1'b1);
      chk("drain_chan", 32'(out_chan), 32'd2);
      chk("drain_valid", 32'(out_valid), 32'd1);

      // sparse with wrap
      step(1'b1, 0, 4'b1000, 32'h7700_0000, 1'b1);
      chk("sp3", 32'(out_chan), 32'd3);
      step(1'b1, 0, 4'b0100, 32'h0066_0000, 1'b1);
      chk("sp2", 32'(out_chan), 32'd2);
      step(1'b1, 0, 4'b0001, 32'h0000_0055, 1'b1);
      chk("sp0", 32'(out_chan), 32'd0);

      // async reset while a word is pending
      step(1'b1, 0, 4'b1111, $urandom, 1'b0);
      #2; rst = 1'b1; #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      model_reset();
      #2; rst = 1'b0;
      step(1'b1, 0, 4'b1111, $urandom, 1'b1);
      chk("arst_first", 32'(out_chan), 32'd0);

`ifdef CHMUX_PARITY_EN
      step(1'b0, 0, 4'b0001, 32'h0000_0007, 1'b1);
      chk("par07", 32'(out_par), 32'd1);
      step(1'b0, 0, 4'b0001, 32'h0000_0003, 1'b1);
      chk("par03", 32'(out_par), 32'd0);
`endif

      for (int i = 0; i < 400; i++)
         step(1'($urandom), int'($urandom_range(0, 3)), 4'($urandom), $urandom,
              ($urandom_range(0, 3) != 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
